lookup_action_queue: RTL

- Sits directly downstream of the static/flow lookup stage.
- Captures each single-cycle lookup result (valid, match, port, vport, type, match address) into an in-order queue.
- Presents results one at a time to the output-queue/packet-forwarding stage with a valid/ready handshake.
- The lookup stage has no backpressure, so this block absorbs bursts. It flags results that must be dropped (no match, or empty port mask) without reordering them, which keeps actions aligned with buffered packets.

---
 rtl/lookup_action_queue.sv | 116 +++++++++++
 1 files changed

// File: rtl/lookup_action_queue.sv
// In-order queue of lookup results feeding the forwarding stage.
// Optional counters: define LOOKUP_ACTION_QUEUE_STATS_EN.
module lookup_action_queue #(
  parameter int C_OUT_PORT_WIDTH   = 8,
  parameter int C_MATCH_ADDR_WIDTH = 10,
  parameter int C_DEPTH_LOG2       = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          action_valid,
  input  logic                          action_match,
  input  logic [C_OUT_PORT_WIDTH-1:0]   action_port,
  input  logic [C_OUT_PORT_WIDTH-1:0]   action_vport,
  input  logic [1:0]                    action_type,
  input  logic [C_MATCH_ADDR_WIDTH-1:0] action_match_addr,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_drop,
  output logic [C_OUT_PORT_WIDTH-1:0]   out_port,
  output logic [C_OUT_PORT_WIDTH-1:0]   out_vport,
  output logic [1:0]                    out_type,
  output logic [C_MATCH_ADDR_WIDTH-1:0] out_match_addr,
  output logic [C_DEPTH_LOG2:0]         occupancy,
  output logic                          overflow
`ifdef LOOKUP_ACTION_QUEUE_STATS_EN
  ,
  output logic [31:0]                   stat_drop_cnt,
  output logic [31:0]                   stat_fwd_cnt,
  output logic [31:0]                   stat_lost_cnt
`endif
);

  localparam int DEPTH = 1 << C_DEPTH_LOG2;
  localparam int EW    = 1 + 2*C_OUT_PORT_WIDTH + 2 + C_MATCH_ADDR_WIDTH;
  localparam logic [C_DEPTH_LOG2:0] FULL_CNT =
    {1'b1, {C_DEPTH_LOG2{1'b0}}};

  logic [EW-1:0]           mem [DEPTH];
  logic [C_DEPTH_LOG2:0]   wr_ptr, rd_ptr;
  logic [C_DEPTH_LOG2:0]   wr_nxt, rd_nxt, cnt, cnt_nxt;
  logic [EW-1:0]           in_ent, head_nxt;
  logic                    in_drop;
  logic                    full, do_pop, do_push, lost, load_head;

  assign in_drop = ~action_match | (action_port == '0);
  assign in_ent  = {in_drop, action_port, action_vport,
                    action_type, action_match_addr};

  assign cnt       = wr_ptr - rd_ptr;
  assign occupancy = cnt;
  assign out_valid = (cnt != '0);
  assign full      = (cnt == FULL_CNT);

  // Handshake decode, next pointers and next head selection.
  // The head lives in its own register so the outputs hold their
  // last values once the queue drains; an entry written this cycle
  // that becomes the new head is bypassed straight from the input.
  always_comb begin
    do_pop    = out_valid & out_ready;
    do_push   = action_valid & (~full | do_pop);
    lost      = action_valid & full & ~do_pop;
    rd_nxt    = rd_ptr + (C_DEPTH_LOG2+1)'(do_pop);
    wr_nxt    = wr_ptr + (C_DEPTH_LOG2+1)'(do_push);
    cnt_nxt   = wr_nxt - rd_nxt;
    load_head = (cnt_nxt != '0) & (do_pop | ~out_valid);
    head_nxt  = (rd_nxt == wr_ptr) ? in_ent
              : mem[rd_nxt[C_DEPTH_LOG2-1:0]];
  end

  // Entry storage; contents need no reset, pointers gate validity.
  always_ff @(posedge clk) begin
    if (resetn && do_push)
      mem[wr_ptr[C_DEPTH_LOG2-1:0]] <= in_ent;
  end

  // Pointers, sticky overflow and head register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      overflow       <= 1'b0;
      out_drop       <= 1'b0;
      out_port       <= '0;
      out_vport      <= '0;
      out_type       <= '0;
      out_match_addr <= '0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      if (lost)
        overflow <= 1'b1;
      if (load_head)
        {out_drop, out_port, out_vport,
         out_type, out_match_addr} <= head_nxt;
    end
  end

`ifdef LOOKUP_ACTION_QUEUE_STATS_EN
  // Saturating pop/loss counters.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      stat_drop_cnt <= '0;
      stat_fwd_cnt  <= '0;
      stat_lost_cnt <= '0;
    end else begin
      if (do_pop && out_drop && stat_drop_cnt != '1)
        stat_drop_cnt <= stat_drop_cnt + 32'd1;
      if (do_pop && !out_drop && stat_fwd_cnt != '1)
        stat_fwd_cnt <= stat_fwd_cnt + 32'd1;
      if (lost && stat_lost_cnt != '1)
        stat_lost_cnt <= stat_lost_cnt + 32'd1;
    end
  end
`endif

endmodule
